// File: rtl/video_pkg.sv
// video_pkg: shared types, constants and helpers for the video object generators.
package video_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, ARMED = 2'd2, DRAW = 2'd3} sprite_state_t;
    localparam int SPRITE_ROWS = 16;
    localparam int SPRITE_WIDTH = 8;
    function automatic logic [4:0] bit_width(input logic [1:0] hsize);
        return 5'd2 << hsize;
    endfunction
    function automatic logic [SPRITE_WIDTH-1:0] reverse_bits(input logic [SPRITE_WIDTH-1:0] b);
        logic [SPRITE_WIDTH-1:0] r;
        for (int i = 0; i < SPRITE_WIDTH; i++) r[i] = b[SPRITE_WIDTH-1-i];
        return r;
    endfunction
endpackage

// File: rtl/sprite_row_mem.sv
// sprite_row_mem: sprite bitmap register file with synchronous write, registered read and clear.
module sprite_row_mem #(
    parameter int ROW_BITS = 4,
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ROW_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [ROW_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]    rd_data
);
    logic [WIDTH-1:0] mem [2**ROW_BITS];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**ROW_BITS; i++) mem[i] <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en) mem[wr_addr] <= wr_data;
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/player_sprite.sv
// player_sprite: fetches one bitmap row per line and serialises it at x_pos with
// stretch/reflect; drives a registered pixel_on and a sticky playfield collision flag.
module player_sprite
    import video_pkg::*;
#(
    parameter int ROW_BITS = 4,
    parameter int POS_BITS = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [POS_BITS-1:0] hpos,
    input  logic [POS_BITS-1:0] vpos,
    input  logic                in_image,
    input  logic                playfield_on,
    input  logic [POS_BITS-1:0] x_pos,
    input  logic [POS_BITS-1:0] y_pos,
    input  logic [1:0]          hsize,
    input  logic [1:0]          vsize,
    input  logic                reflect,
    input  logic                wr_en,
    input  logic [ROW_BITS-1:0] wr_addr,
    input  logic [7:0]          wr_data,
    input  logic                collision_clear,
    output logic                pixel_on,
    output logic                collision,
    output logic                busy
);
    sprite_state_t state_q, state_d;
    logic [SPRITE_WIDTH-1:0] shreg, rd_data;
    logic [3:0] pix_cnt;
    logic [2:0] bit_cnt;
    logic [POS_BITS-1:0] d;
    logic [ROW_BITS-1:0] rd_addr;
    logic line_start, visible, hit, drawing, cur_bit, last_pix, last_bit;

    // The row is read on the line_start edge so FETCH sees registered data; a
    // write landing during FETCH therefore only shows up on the following line.
    sprite_row_mem #(.ROW_BITS(ROW_BITS), .WIDTH(SPRITE_WIDTH)) u_mem (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    always_comb begin
        line_start = hpos == '0;
        d = vpos - y_pos;
        visible = vpos >= y_pos && d < (POS_BITS'(2**ROW_BITS) << vsize);
        rd_addr = ROW_BITS'(d >> vsize);
        hit = state_q == ARMED && hpos == x_pos;
        drawing = (state_q == DRAW || hit) && !line_start;
        cur_bit = shreg[SPRITE_WIDTH-1];
        last_pix = {1'b0, pix_cnt} >= bit_width(hsize) - 5'd1;
        last_bit = bit_cnt == 3'(SPRITE_WIDTH - 1);
        state_d = state_q;
        if (line_start) state_d = visible ? FETCH : IDLE;
        else if (state_q == FETCH) state_d = ARMED;
        else if (hit) state_d = DRAW;
        else if (state_q == DRAW && last_pix && last_bit) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            pix_cnt <= '0;
            bit_cnt <= '0;
            pixel_on <= 1'b0;
            collision <= 1'b0;
        end else begin
            pixel_on <= drawing && cur_bit && in_image;
            if (drawing && cur_bit && in_image && playfield_on) collision <= 1'b1;
            else if (collision_clear) collision <= 1'b0;
            if (state_q == FETCH) begin
                shreg <= reflect ? reverse_bits(rd_data) : rd_data;
                pix_cnt <= '0;
                bit_cnt <= '0;
            end else if (drawing) begin
                if (last_pix) begin
                    shreg <= {shreg[SPRITE_WIDTH-2:0], 1'b0};
                    pix_cnt <= '0;
                    bit_cnt <= bit_cnt + 3'd1;
                end else begin
                    pix_cnt <= pix_cnt + 4'd1;
                end
            end
        end
    end

    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_player_sprite.sv
// tb_player_sprite: scans video lines against a per-pixel reference of the sprite rules.
`timescale 1ns/1ps
module tb_player_sprite;
    logic clk = 0, reset = 0;
    logic [9:0] hpos = 0, vpos = 0, x_pos = 0, y_pos = 0;
    logic in_image = 0, playfield_on = 0, reflect = 0, wr_en = 0, collision_clear = 0;
    logic [1:0] hsize = 0, vsize = 0;
    logic [3:0] wr_addr = 0;
    logic [7:0] wr_data = 0;
    logic pixel_on, collision, busy;

    int n_cmp = 0, n_err = 0, img_w = 1024;
    logic [7:0] mem_m [16];
    bit pf [1024];
    logic [1023:0] obs;
    logic col_m = 0;

    always #5 clk = ~clk;

    player_sprite dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .in_image(in_image),
        .playfield_on(playfield_on), .x_pos(x_pos), .y_pos(y_pos), .hsize(hsize),
        .vsize(vsize), .reflect(reflect), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .collision_clear(collision_clear), .pixel_on(pixel_on),
        .collision(collision), .busy(busy)
    );

    function automatic logic model_pix(input int h, input int v);
        int x = int'(x_pos), y = int'(y_pos), bw = 2 << hsize, k;
        logic [7:0] r;
        if (x < 2 || v < y || v - y >= (16 << vsize) || h < x || h >= x + 8 * bw || h >= img_w) return 0;
        k = (h - x) / bw;
        r = mem_m[(v - y) >> vsize];
        return reflect ? r[k] : r[7 - k];
    endfunction

    function automatic int count_on();
        int c = 0;
        for (int i = 0; i < 1024; i++) c += int'(obs[i]);
        return c;
    endfunction

    task automatic idle_inputs();
        hpos = 10'd1023; vpos = 10'd1023; in_image = 0; playfield_on = 0;
        collision_clear = 0; wr_en = 0;
    endtask

    task automatic clear_pf();
        for (int i = 0; i < 1024; i++) pf[i] = 0;
    endtask

    task automatic write_row(input int a, input logic [7:0] dat);
        idle_inputs();
        wr_en = 1; wr_addr = 4'(a); wr_data = dat;
        @(posedge clk); #1;
        wr_en = 0;
        mem_m[a] = dat;
    endtask

    task automatic scan_line(input int v, input int len, input int clr_h, input int wr_h,
                             input int wr_a, input logic [7:0] wr_d, input string tag);
        int bad = 0, first = -1;
        logic eo, go = 0, gc = 0, wo = 0, wc = 0;
        obs = '0;
        for (int h = 0; h < len; h++) begin
            hpos = 10'(h); vpos = 10'(v); in_image = h < img_w; playfield_on = pf[h];
            collision_clear = h == clr_h; wr_en = h == wr_h; wr_addr = 4'(wr_a); wr_data = wr_d;
            eo = model_pix(h, v);
            col_m = (eo && pf[h]) ? 1'b1 : (h == clr_h ? 1'b0 : col_m);
            @(posedge clk); #1;
            obs[h] = pixel_on;
            if (pixel_on !== eo || collision !== col_m) begin
                if (first < 0) begin first = h; go = pixel_on; gc = collision; wo = eo; wc = col_m; end
                bad++;
            end
        end
        idle_inputs();
        if (wr_h >= 0) mem_m[wr_a] = wr_d;
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL %s vpos=%0d: %0d bad pixels, first hpos %0d got pix=%b col=%b want pix=%b col=%b",
                     tag, v, bad, first, go, gc, wo, wc);
        end
    endtask

    task automatic set_cfg(input int x, input int y, input int hs, input int vs, input logic rf);
        x_pos = 10'(x); y_pos = 10'(y); hsize = 2'(hs); vsize = 2'(vs); reflect = rf;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({pixel_on, collision, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_outputs got %b want 000", {pixel_on, collision, busy});
        end
        reset = 0;
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        col_m = 0;
        clear_pf();
        set_cfg(100, 10, 0, 0, 0);
        scan_line(10, 300, -1, -1, 0, 8'h00, "reset_bitmap_zero");
        n_cmp++;
        if (count_on() !== 0) begin
            n_err++;
            $display("FAIL reset_bitmap_zero got %0d pixels want 0", count_on());
        end
    endtask

    task automatic test_basic();
        logic [15:0] pat;
        write_row(0, 8'hA5);
        set_cfg(100, 10, 0, 0, 0);
        scan_line(10, 300, -1, -1, 0, 8'h00, "basic_row");
        for (int i = 0; i < 16; i++) pat[15 - i] = obs[100 + i];
        n_cmp++;
        if (pat !== 16'hCC33) begin
            n_err++;
            $display("FAIL basic_pattern got %h want cc33", pat);
        end
        scan_line(9, 300, -1, -1, 0, 8'h00, "basic_above");
        n_cmp++;
        if (count_on() !== 0) begin n_err++; $display("FAIL basic_above got %0d want 0", count_on()); end
        scan_line(26, 300, -1, -1, 0, 8'h00, "basic_below");
        n_cmp++;
        if (count_on() !== 0) begin n_err++; $display("FAIL basic_below got %0d want 0", count_on()); end
    endtask

    task automatic test_reflect_stretch();
        write_row(0, 8'h80);
        set_cfg(100, 10, 3, 0, 1);
        scan_line(10, 300, -1, -1, 0, 8'h00, "reflect_stretch");
        n_cmp++;
        if (count_on() !== 16 || obs[211] !== 1'b0 || obs[212] !== 1'b1 || obs[227] !== 1'b1 || obs[228] !== 1'b0) begin
            n_err++;
            $display("FAIL reflect_stretch got count=%0d edges=%b%b%b%b want count=16 edges=0110",
                     count_on(), obs[211], obs[212], obs[227], obs[228]);
        end
    endtask

    task automatic test_vstretch();
        for (int i = 0; i < 16; i++) write_row(i, 8'(i));
        set_cfg(100, 20, 0, 2, 0);
        for (int l = 0; l < 8; l++) scan_line(20 + l, 200, -1, -1, 0, 8'h00, "vstretch");
        n_cmp++;
        if (count_on() !== 2 || obs[114] !== 1'b1 || obs[115] !== 1'b1) begin
            n_err++;
            $display("FAIL vstretch_row1 got count=%0d want 2 at hpos 114..115", count_on());
        end
        scan_line(83, 200, -1, -1, 0, 8'h00, "vstretch_last");
        scan_line(84, 200, -1, -1, 0, 8'h00, "vstretch_past");
        n_cmp++;
        if (count_on() !== 0) begin n_err++; $display("FAIL vstretch_past got %0d want 0", count_on()); end
    endtask

    task automatic test_right_edge();
        for (int i = 0; i < 16; i++) write_row(i, 8'hFF);
        set_cfg(850, 10, 3, 0, 0);
        scan_line(10, 858, -1, -1, 0, 8'h00, "edge_line");
        scan_line(11, 858, -1, -1, 0, 8'h00, "edge_next");
        n_cmp++;
        if (count_on() !== 8) begin n_err++; $display("FAIL edge_no_wrap got %0d want 8", count_on()); end
        hpos = 0; vpos = 12; in_image = 1;
        @(posedge clk); #1;
        n_cmp++;
        if (pixel_on !== 1'b0) begin n_err++; $display("FAIL edge_drop got %b want 0", pixel_on); end
        hpos = 1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b1 || pixel_on !== 1'b0) begin
            n_err++;
            $display("FAIL edge_rearm got busy=%b pix=%b want busy=1 pix=0", busy, pixel_on);
        end
        idle_inputs();
    endtask

    task automatic test_collision();
        write_row(0, 8'h81);
        set_cfg(100, 10, 0, 0, 0);
        clear_pf();
        pf[101] = 1; pf[102] = 1;
        scan_line(10, 300, -1, -1, 0, 8'h00, "collision_set");
        n_cmp++;
        if (collision !== 1'b1) begin n_err++; $display("FAIL collision_sticky got %b want 1", collision); end
        scan_line(10, 300, 101, -1, 0, 8'h00, "collision_set_wins");
        n_cmp++;
        if (collision !== 1'b1) begin n_err++; $display("FAIL collision_set_wins got %b want 1", collision); end
        clear_pf();
        scan_line(10, 300, 150, -1, 0, 8'h00, "collision_clear");
        n_cmp++;
        if (collision !== 1'b0) begin n_err++; $display("FAIL collision_clear got %b want 0", collision); end
    endtask

    task automatic test_hazard();
        write_row(0, 8'h3C);
        set_cfg(100, 10, 0, 0, 0);
        scan_line(10, 300, -1, 1, 0, 8'hFF, "hazard_old");
        n_cmp++;
        if (count_on() !== 8) begin n_err++; $display("FAIL hazard_old got %0d want 8", count_on()); end
        scan_line(10, 300, -1, -1, 0, 8'h00, "hazard_new");
        n_cmp++;
        if (count_on() !== 16) begin n_err++; $display("FAIL hazard_new got %0d want 16", count_on()); end
    endtask

    task automatic test_reset_mid_draw();
        write_row(0, 8'hFF);
        set_cfg(100, 10, 1, 0, 0);
        for (int h = 0; h < 105; h++) begin
            hpos = 10'(h); vpos = 10; in_image = 1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (pixel_on !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_draw got pix=%b busy=%b want 11", pixel_on, busy);
        end
        reset = 1; hpos = 105;
        @(posedge clk); #1;
        reset = 0;
        n_cmp++;
        if (pixel_on !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_draw got pix=%b busy=%b want 00", pixel_on, busy);
        end
        idle_inputs();
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        col_m = 0;
    endtask

    task automatic test_random();
        int y, v, rows;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 16; i++) write_row(i, 8'($urandom));
            y = $urandom_range(1, 100);
            set_cfg($urandom_range(2, 450), y, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
            img_w = $urandom_range(200, 600);
            for (int i = 0; i < 1024; i++) pf[i] = $urandom_range(0, 3) == 0;
            rows = 16 << vsize;
            for (int l = 0; l < 4; l++) begin
                v = y - 1 + $urandom_range(0, rows + 1);
                scan_line(v, 560, $urandom_range(0, 600), -1, 0, 8'h00, "random");
            end
        end
        img_w = 1024;
        clear_pf();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reflect_stretch();
        test_vstretch();
        test_right_edge();
        test_collision();
        test_hazard();
        test_reset_mid_draw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/player_sprite.md
# player_sprite

Atari-style player object generator for the pixel-clock video path. Holds a 16-row × 8-bit bitmap and per-line fetches the row selected by `vpos`. Serialises it horizontally at `x_pos` with configurable stretch and reflect, and produces a registered `pixel_on` that the playfield colour mux consumes to select `color_p0`/`color_p1`. Also latches a sticky playfield collision flag.

## Interface
- `ROW_BITS`, 4: log2 of bitmap rows (16 rows).
- `POS_BITS`, 10: width of `hpos`/`vpos`/`x_pos`/`y_pos`.
- `clk` in 1: pixel clock (driven from `clk_pixel`).
- `reset` in 1: synchronous, active-high.
- `hpos` in 10: current horizontal pixel from the HDMI timing block.
- `vpos` in 10: current line.
- `in_image` in 1: active-area flag.
- `playfield_on` in 1: playfield foreground at this pixel, same-cycle aligned with `hpos`.
- `x_pos` in 10: left edge of the sprite, in pixels.
- `y_pos` in 10: first line of the sprite.
- `hsize` in 2: horizontal stretch; bit width = 2 << hsize pixels (2, 4, 8, 16).
- `vsize` in 2: vertical stretch; each row repeats 1 << vsize lines.
- `reflect` in 1: 0 = MSB drawn first, 1 = LSB drawn first.
- `wr_en` in 1: bitmap write strobe.
- `wr_addr` in 4: bitmap row to write.
- `wr_data` in 8: row data.
- `collision_clear` in 1: clears the sticky collision flag.
- `pixel_on` out 1: sprite foreground; registered.
- `collision` out 1: sticky flag, set on sprite/playfield overlap.
- `busy` out 1: high while state ≠ IDLE; for debug and the bench.

## Operation
- Bitmap: 16×8 flip-flop array.
  - Written when `wr_en`=1: `mem[wr_addr] <= wr_data`.
  - Cleared to 0 by reset.
- `line_start` = (`hpos` == 0).
- States: IDLE, FETCH, ARMED, DRAW.
- IDLE → FETCH on `line_start`.
  - Row offset: `d = vpos - y_pos`, computed at 10 bits, unsigned.
  - Visible iff `vpos >= y_pos` and `d < (16 << vsize)`.
  - Visible: FETCH latches `row_addr = d >> vsize`.
  - Not visible: return to IDLE.
- FETCH (1 cycle): `shreg <= mem[row_addr]`; `bit_cnt <= 0`; `pix_cnt <= 0`.
  - If `reflect`=1, load the byte bit-reversed.
  - → ARMED.
- ARMED: wait for `hpos == x_pos`; → DRAW on that cycle.
  - The first sprite bit is evaluated on that same cycle.
- DRAW:
  - Current bit = `shreg[7]`.
  - `pix_cnt` increments each cycle; on `pix_cnt == (2 << hsize) - 1`: shift `shreg` left, `pix_cnt <= 0`, `bit_cnt++`.
  - After the 8th bit completes → IDLE.
- `line_start` in any state forces the line restart; a sprite running off the right edge is truncated, never wrapped onto the next line.
- `hsize`, `vsize`, `reflect`, `x_pos`, `y_pos` are sampled live. Upstream changes them only in vblank; mid-line changes have undefined appearance but must never hang the FSM.
- `pixel_on` next = (state == DRAW) && current bit && `in_image`.
- Collision:
  - `collision <= 1` when (state == DRAW && current bit && `playfield_on` && `in_image`).
  - Else cleared by `collision_clear`.
  - Set wins over a same-cycle clear.

## Timing
- Reset values: state IDLE; `pixel_on`=0, `collision`=0, `busy`=0; bitmap all 0.
- Reset mid-DRAW aborts immediately; `pixel_on` is 0 on the cycle after reset.
- Latency: `pixel_on` is high exactly one cycle after the `clk` edge where `hpos == x_pos` with bit set. The colour mux compensates with one delay stage.
- Write/read hazard: a write to the row being fetched in the same FETCH cycle returns the old data; the new data is visible from the next line.
- `x_pos` == 0 or `x_pos` == 1 is unreachable in that line (FETCH occupies `hpos` 1). The sprite is not drawn; no error.
- `y_pos + (16 << vsize)` past the frame end: rows beyond the last line are simply never reached.
- The 10-bit subtraction wraps; the `vpos >= y_pos` guard rejects wrapped values.

## Structure
- Package `video_pkg`:
  - state enum `sprite_state_t`: IDLE=0, FETCH=1, ARMED=2, DRAW=3.
  - constants `SPRITE_ROWS`=16 and `SPRITE_WIDTH`=8.
  - function `bit_width(hsize)` returning `2 << hsize`.
- Sub-module `sprite_row_mem`: 16×8 register file with synchronous write, registered read and synchronous clear.
- FSM and serialiser stay in `player_sprite`.

## Test plan
- Basic row at `hpos` 100:
  - Setup: row 0 = 8'hA5, `y_pos`=10, `x_pos`=100, `hsize`=0, `vsize`=0, `reflect`=0.
  - At `vpos`=10, `pixel_on` pattern over `hpos` 100..115 is 11 00 11 00 00 11 00 11, delayed 1 cycle.
  - `vpos`=9 and `vpos`=26 give all zeros.
- Reflect and stretch:
  - Setup: row 0 = 8'h80, `reflect`=1, `hsize`=3.
  - Only the last 16 pixels (`hpos` 212..227 for `x_pos`=100) are on.
- Vertical stretch:
  - Setup: `vsize`=2, rows 0..15 = row index.
  - Lines `y_pos`..`y_pos`+3 show 8'h00; lines +4..+7 show 8'h01; line +64 is blank.
- Right-edge truncation:
  - Setup: `x_pos`=850, total line length 858, `hsize`=3.
  - `pixel_on` drops at `line_start` and the FSM reaches ARMED for the new line.
  - No wrap to `hpos` 0..n.
- Collision:
  - Sprite overlaps a `playfield_on` pixel → `collision`=1 the next cycle and stays 1.
  - Overlap coinciding with `collision_clear` → stays 1.
  - Clear alone → 0.
- Reset mid-DRAW and write hazard:
  - `reset` pulse during DRAW → `pixel_on`=0, `busy`=0 the next cycle.
  - Write 8'hFF to the fetched row during FETCH → old data is drawn; 8'hFF appears on the next line.
